fmul_pipe: RTL
==============

FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, pipeline depth in cycles; legal range 1..4.
REQ-002 SHALL have parameter TAGW, default 4, width of sideband tag carried alongside each operation.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports x1, x2  in  32 each  IEEE-754 single operands.
REQ-006 SHALL have port in_tag  in  TAGW  tag captured with the operands.
REQ-007 SHALL have port in_valid  in  1  operands valid this cycle.
REQ-008 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-009 SHALL have port y  out  32  product.
REQ-010 SHALL have port out_tag  out  TAGW  tag of the op presented on y.
REQ-011 SHALL have ports ovf, unf  out  1 each  exponent overflow / underflow flags for the op on y.
REQ-012 SHALL have port out_valid  out  1  y/out_tag/ovf/unf valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result.

Function
REQ-014 SHALL use one global advance = ~out_valid | out_ready; all stages shift only when advance=1; in_ready SHALL equal advance.
REQ-015 SHALL accept an op when in_valid & in_ready; a bubble (valid=0) SHALL be inserted when in_valid=0 and advance=1.
REQ-016 SHALL present an accepted op on y exactly NSTAGE cycles later when advance stays 1; sustained throughput one op per cycle.
REQ-017 SHALL hold y, out_tag, ovf, unf, out_valid stable while out_valid=1 and out_ready=0; no op lost or duplicated.
REQ-018 SHALL compute sign = x1[31]^x2[31] in all cases.
REQ-019 SHALL treat any operand with exponent 0 as zero (denormals flushed); result {sign,31'b0}, ovf=0, unf=0; zero takes priority over REQ-020.
REQ-020 SHALL treat any operand with exponent 255 as infinity (NaN not distinguished); result {sign,8'hFF,23'b0}, ovf=0, unf=0.
REQ-021 SHALL form the exact 48-bit product of the two 24-bit significands (hidden 1 restored); no partial-product truncation.
REQ-022 SHALL normalise: if product bit 47 set, take bits 46:24 and add 1 to exponent; else take bits 45:23.
REQ-023 SHALL compute biased exponent as e1+e2-127 (+ normalise / rounding carry) in at least 10-bit signed arithmetic.
REQ-024 SHALL, when final exponent >= 255, output {sign,8'hFF,23'b0} with ovf=1.
REQ-025 SHALL, when final exponent <= 0, output {sign,31'b0} with unf=1.
REQ-026 SHALL split work across NSTAGE register stages (partial products, sum, normalise/round/pack); result SHALL be identical for every legal NSTAGE.

Reset
REQ-027 SHALL, while rstn=0 at a clock edge, clear every stage valid bit; out_valid=0 one cycle after; y, out_tag, ovf, unf SHALL read 0 after reset.
REQ-028 SHALL discard all in-flight ops on reset mid-operation; no stale result SHALL emerge after rstn returns to 1.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-030 SHALL, with macro FMUL_RNE_EN defined, round to nearest-even using guard bit and sticky OR of remaining low bits; mantissa carry-out SHALL increment exponent and re-check REQ-024.
REQ-031 SHALL, without FMUL_RNE_EN, truncate (discard all bits below the 23-bit mantissa).

Verification
REQ-032 SHALL cover: x1=0x40000000, x2=0x40400000, out_ready=1 -> y=0x40C00000 exactly NSTAGE cycles after accept, ovf=unf=0.
REQ-033 SHALL cover: x1=x2=0x7F000000 -> y=0x7F800000, ovf=1; x1=x2=0x00800000 -> y=0x00000000, unf=1.
REQ-034 SHALL cover: x1=0x3F800001, x2=0x3FC00000 -> y=0x3FC00001 without FMUL_RNE_EN, y=0x3FC00002 with it.
REQ-035 SHALL cover: back-to-back ops with tags 0..7, out_ready low for 5 cycles mid-stream -> results in order, tags match, in_ready=0 while stalled, none lost.
REQ-036 SHALL cover: x1=0x00000000, x2=0xFF800000 -> y=0x80000000; x1=0xC0000000, x2=0x7F800000 -> y=0xFF800000.
REQ-037 SHALL cover: rstn pulsed low with 2 ops in flight -> out_valid stays 0 until a new op is accepted and completes.

Source files
------------

// File: rtl/fmul_pipe.sv
// fmul_pipe -- pipelined IEEE-754 single-precision multiplier
//
// Latency is NSTAGE cycles (1..4) and throughput is one op per cycle.
// Every stage moves on a single shared advance signal, so a stalled
// consumer freezes the whole pipe and back-pressures the producer.
// Denormal operands are flushed to zero. NaN is treated as infinity.
//
// Build option:
//   FMUL_RNE_EN  defined   -> round to nearest-even (guard + sticky)
//                undefined -> truncate to 23 mantissa bits
//
// Parameters:
//   NSTAGE     pipeline depth in cycles, 1..4
//   TAGW       sideband tag width
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset
//   x1, x2     operands
//   in_tag     tag carried with the operands
//   in_valid   operands valid
//   in_ready   operands accepted this cycle (equals advance)
//   y          product
//   out_tag    tag of the op on y
//   ovf, unf   exponent overflow / underflow for the op on y
//   out_valid  y/out_tag/ovf/unf valid
//   out_ready  consumer accepts the result
module fmul_pipe #(
    parameter int NSTAGE = 3,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [31:0]     x1,
    input  logic [31:0]     x2,
    input  logic [TAGW-1:0] in_tag,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     y,
    output logic [TAGW-1:0] out_tag,
    output logic            ovf,
    output logic            unf,
    output logic            out_valid,
    input  logic            out_ready
);

    // First stage: classified operands plus two 24x12 partial products.
    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic            sign;
        logic            zero;
        logic            inf;
        logic [9:0]      exp;     // e1+e2-127, two's complement
        logic [35:0]     pp_hi;   // sig1 * sig2[23:12]
        logic [35:0]     pp_lo;   // sig1 * sig2[11:0]
    } mid_t;

    // Final result, as presented on the outputs.
    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [31:0]     y;
        logic            ovf;
        logic            unf;
    } res_t;

    logic advance;
    res_t out_q;

    assign advance  = ~out_q.valid | out_ready;
    assign in_ready = advance;

    function automatic mid_t decode(input logic            v,
                                    input logic [TAGW-1:0] t,
                                    input logic [31:0]     a,
                                    input logic [31:0]     b);
        mid_t        m;
        logic [23:0] sa;
        logic [23:0] sb;
        sa      = {1'b1, a[22:0]};
        sb      = {1'b1, b[22:0]};
        m.valid = v;
        m.tag   = t;
        m.sign  = a[31] ^ b[31];
        m.zero  = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
        m.inf   = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        m.exp   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        m.pp_hi = {12'b0, sa} * {24'b0, sb[23:12]};
        m.pp_lo = {12'b0, sa} * {24'b0, sb[11:0]};
        return m;
    endfunction

    function automatic res_t pack(input mid_t m);
        res_t        r;
        logic [47:0] prod;
        logic [22:0] mant;
        logic [9:0]  e;
`ifdef FMUL_RNE_EN
        logic        guard;
        logic        sticky;
        logic        carry;
`endif
        prod = {m.pp_hi, 12'b0} + {12'b0, m.pp_lo};
        if (prod[47]) begin
            mant = prod[46:24];
            e    = m.exp + 10'd1;
`ifdef FMUL_RNE_EN
            guard  = prod[23];
            sticky = |prod[22:0];
`endif
        end else begin
            mant = prod[45:23];
            e    = m.exp;
`ifdef FMUL_RNE_EN
            guard  = prod[22];
            sticky = |prod[21:0];
`endif
        end
`ifdef FMUL_RNE_EN
        // A carry out of the mantissa means the significand reached 2.0;
        // the wrapped mantissa of zero is then correct for 1.0 * 2^(e+1).
        {carry, mant} = {1'b0, mant} + {23'b0, guard & (sticky | mant[0])};
        if (carry) begin
            e = e + 10'd1;
        end
`endif
        r.valid = m.valid;
        r.tag   = m.tag;
        r.ovf   = 1'b0;
        r.unf   = 1'b0;
        if (m.zero) begin
            r.y = {m.sign, 31'b0};
        end else if (m.inf) begin
            r.y = {m.sign, 8'hFF, 23'b0};
        end else if ($signed(e) >= 10'sd255) begin
            r.y   = {m.sign, 8'hFF, 23'b0};
            r.ovf = 1'b1;
        end else if ($signed(e) <= 10'sd0) begin
            r.y   = {m.sign, 31'b0};
            r.unf = 1'b1;
        end else begin
            r.y = {m.sign, e[7:0], mant};
        end
        return r;
    endfunction

    generate
        if (NSTAGE == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    out_q <= '0;
                end else if (advance) begin
                    out_q <= pack(decode(in_valid, in_tag, x1, x2));
                end
            end
        end else begin : g_multi
            mid_t mid_q;
            res_t res_q [NSTAGE-1];

            // Stage 1 holds partial products; stage 2 sums, normalises and
            // packs; any further stages only add delay.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    mid_q <= '0;
                    for (int i = 0; i < NSTAGE - 1; i++) begin
                        res_q[i] <= '0;
                    end
                end else if (advance) begin
                    mid_q    <= decode(in_valid, in_tag, x1, x2);
                    res_q[0] <= pack(mid_q);
                    for (int i = 1; i < NSTAGE - 1; i++) begin
                        res_q[i] <= res_q[i-1];
                    end
                end
            end

            assign out_q = res_q[NSTAGE-2];
        end
    endgenerate

    assign y         = out_q.y;
    assign out_tag   = out_q.tag;
    assign ovf       = out_q.ovf;
    assign unf       = out_q.unf;
    assign out_valid = out_q.valid;

endmodule
